// File: rtl/clock_monitor_if.sv
// Handshake-free status bundle between the clock divider side and the monitor.
// master drives the clocks under test and clr_err; slave returns lock/error status.
interface clock_monitor_if #(
    parameter int CNT_W = 8
);
    logic             w_clk_in;
    logic             r_clk_in;
    logic             clr_err;
    logic             w_locked;
    logic             r_locked;
    logic             w_err;
    logic             r_err;
    logic [CNT_W-1:0] w_period;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] w_err_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    modport master (
        output w_clk_in, r_clk_in, clr_err,
        input  w_locked, r_locked, w_err, r_err,
        input  w_period, r_period, w_err_cnt, r_err_cnt
    );

    modport slave (
        input  w_clk_in, r_clk_in, clr_err,
        output w_locked, r_locked, w_err, r_err,
        output w_period, r_period, w_err_cnt, r_err_cnt
    );
endinterface

// File: rtl/clock_monitor.sv
// Half-period monitor for the divided write/read clocks, sampled on clk_in.
// Each channel tracks lock, last half-period and sticky loss-of-lock errors.
module clock_monitor_ch #(
    parameter int HALF       = 2,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             clk_meas,
    input  logic             clr_err,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] err_cnt
);
    localparam logic [1:0] UNLOCKED = 2'd0;
    localparam logic [1:0] LOCKING  = 2'd1;
    localparam logic [1:0] LOCKED   = 2'd2;

    localparam logic [CNT_W-1:0] HALF_V = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ALL1   = {CNT_W{1'b1}};
    localparam logic [3:0]       LC_V   = 4'(LOCK_COUNT);

    logic             s1, s2, s3;
    logic [CNT_W-1:0] run;
    logic [1:0]       state;
    logic [3:0]       good;
    logic             tog, match, bad, lost;

    assign tog    = s2 ^ s3;
    assign match  = tog && (run == HALF_V);
    // a missing edge is caught exactly once, when run reaches HALF
    assign bad    = (tog && (run != HALF_V)) || (!tog && (run == HALF_V));
    assign lost   = (state == LOCKED) && bad;
    assign locked = (state == LOCKED);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            run     <= '0;
            period  <= '0;
            state   <= UNLOCKED;
            good    <= 4'd0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            s1 <= clk_meas;
            s2 <= s1;
            s3 <= s2;

            if (tog)
                run <= ONE;
            else if (run != ALL1)
                run <= run + ONE;

            if (tog)
                period <= run;

            case (state)
                UNLOCKED: begin
                    if (tog) begin
                        state <= LOCKING;
                        good  <= 4'd0;
                    end
                end
                LOCKING: begin
                    if (match) begin
                        good <= good + 4'd1;
                        if (good + 4'd1 == LC_V)
                            state <= LOCKED;
                    end else if (bad) begin
                        good <= 4'd0;
                    end
                end
                LOCKED: begin
                    if (bad)
                        state <= UNLOCKED;
                end
                default: state <= UNLOCKED;
            endcase

            // a loss of lock outranks a simultaneous clear
            if (lost) begin
                err <= 1'b1;
                if (clr_err)
                    err_cnt <= ONE;
                else if (err_cnt != ALL1)
                    err_cnt <= err_cnt + ONE;
            end else if (clr_err) begin
                err     <= 1'b0;
                err_cnt <= '0;
            end
        end
    end
endmodule

module clock_monitor #(
    parameter int W_HALF     = 2,
    parameter int R_HALF     = 3,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 8
) (
    input logic           clk_in,
    input logic           reset,
    clock_monitor_if.slave bus
);
    clock_monitor_ch #(
        .HALF(W_HALF), .LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W)
    ) u_w (
        .clk_in  (clk_in),
        .reset   (reset),
        .clk_meas(bus.w_clk_in),
        .clr_err (bus.clr_err),
        .locked  (bus.w_locked),
        .err     (bus.w_err),
        .period  (bus.w_period),
        .err_cnt (bus.w_err_cnt)
    );

    clock_monitor_ch #(
        .HALF(R_HALF), .LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W)
    ) u_r (
        .clk_in  (clk_in),
        .reset   (reset),
        .clk_meas(bus.r_clk_in),
        .clr_err (bus.clr_err),
        .locked  (bus.r_locked),
        .err     (bus.r_err),
        .period  (bus.r_period),
        .err_cnt (bus.r_err_cnt)
    );
endmodule

// File: doc/clock_monitor.md
# clock_monitor

Measures the two divided clocks (write and read) in the source clock domain and reports whether each one is toggling at its programmed half-period. It sits beside the clock divider and takes the divider's write and read clock outputs as plain data inputs, sampled on `clk_in`. It gives FIFO control logic a per-clock lock indication, the last measured half-period, and sticky error status with a saturating error count.

## Interface
- `W_HALF`, default 2: expected write-clock half-period, in `clk_in` cycles.
- `R_HALF`, default 3: expected read-clock half-period, in `clk_in` cycles.
- `LOCK_COUNT`, default 4: consecutive matching half-periods needed to declare lock (range 1..15).
- `CNT_W`, default 8: width of period and error counters. Both `W_HALF+1` and `R_HALF+1` must be below `2^CNT_W`.
- `clk_in` input 1: single clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `w_clk_in` input 1: write clock under test, sampled as data.
- `r_clk_in` input 1: read clock under test, sampled as data.
- `clr_err` input 1: synchronous clear of `w_err`, `r_err`, `w_err_cnt` and `r_err_cnt`.
- `w_locked`, `r_locked` output 1: channel is in the LOCKED state.
- `w_err`, `r_err` output 1: sticky flag, set when a locked channel loses lock.
- `w_period`, `r_period` output CNT_W: last measured half-period.
- `w_err_cnt`, `r_err_cnt` output CNT_W: loss-of-lock count, saturating at `2^CNT_W-1`.

## Operation
The two channels are identical and independent; each uses its own HALF parameter.
- **Input path:** 3 flops (`s1`, `s2`, `s3`). `s1`/`s2` form the synchronizer; `s3` holds the previous value. `edge = s2 ^ s3`, counting both rising and falling transitions.
- **Run counter `run`** (CNT_W bits):
  - On `edge`: `run <= 1`.
  - Otherwise: `run <= run+1`, saturating at all-ones.
  - When `edge` is seen, `run` equals the number of cycles since the previous edge.
- **Period output:** on every `edge`, `period <= run`.
- **Match and timeout:**
  - `match = edge && run == HALF`.
  - `mismatch = edge && run != HALF`.
  - `timeout = !edge && run == HALF`. This fires once per stall: the next value would be HALF+1.
- **State machine** (2-bit state, plus a 4-bit `good` counter):
  - UNLOCKED:
    - `edge` moves to LOCKING with `good <= 0`. This first edge is not judged.
    - Nothing else changes state.
  - LOCKING:
    - `match` increments `good`. When `good+1 == LOCK_COUNT`, move to LOCKED.
    - `mismatch` or `timeout` sets `good <= 0` and stays in LOCKING. No error is recorded.
  - LOCKED:
    - `match` stays in LOCKED.
    - `mismatch` or `timeout` moves to UNLOCKED, sets `err <= 1`, and increments `err_cnt` (saturating).
- **Output mapping:** `locked = (state == LOCKED)`, registered from the state.
- **Error clear:**
  - `clr_err` sets `err <= 0` and `err_cnt <= 0`.
  - If a loss-of-lock event occurs in the same cycle, the event wins: `err = 1`, `err_cnt = 1`.
- **Reset values:**
  - All flops are 0, `run = 0` and state is UNLOCKED.
  - All outputs are 0: `locked`, `err`, `period` and `err_cnt`.
  - Reset is asserted asynchronously. Deassertion is treated as synchronous to `clk_in` by the system.
- **Reset mid-operation:** aborts any lock immediately; outputs are 0 in the same cycle that `reset` rises.

## Timing
- **Edge latency:** a transition on `w_clk_in`/`r_clk_in` first captured at rising edge n sets `edge` during cycle n+2. The resulting `run`, `period`, state and `err` updates are registered at rising edge n+2.
- **Lock latency:** `locked` rises on the same clock as the LOCK_COUNT-th consecutive matching edge. This is 1 + LOCK_COUNT detected transitions after leaving UNLOCKED.
- **Stuck detection:** for a clock stuck after an edge at cycle t, `timeout` is registered at rising edge t+HALF. `locked` and `err` change at that edge.
- **`clr_err`:** takes effect at the next rising edge. `locked` and `period` are unaffected.
- No combinational paths from inputs to outputs.

## Test plan
- **Nominal lock:**
  - Stimulus: after reset, toggle `w_clk_in` every 2 cycles and `r_clk_in` every 3 cycles.
  - Required: `w_period` = 2 and `r_period` = 3. `w_locked` rises on the 5th detected `w_clk_in` transition; `r_locked` rises on the 5th `r_clk_in` transition. `w_err` = 0 and `r_err` = 0.
- **Stuck clock:**
  - Stimulus: with both locked, hold `w_clk_in` constant.
  - Required: exactly 2 cycles after the last `w` edge registers, `w_locked` drops to 0, `w_err` goes to 1 and `w_err_cnt` = 1. The `r` channel is unaffected.
- **Glitch:**
  - Stimulus: with `r` locked, make one `r_clk_in` half-period 1 cycle long.
  - Required: `r_period` = 1, `r_locked` = 0, `r_err_cnt` increments by 1. Resuming 3-cycle toggling relocks after 5 transitions.
- **Mismatch while locking:**
  - Stimulus: feed half-periods 2,2,3,2,2,2,2 on `w`.
  - Required: `good` resets at the half-period of 3. `w_locked` only after the 4 following matches. `w_err` stays 0.
- **Clear:**
  - Stimulus: `clr_err` pulse with `w_err_cnt` = 3.
  - Required: `w_err_cnt` = 0 and `w_err` = 0 next cycle. In a separate run, `clr_err` in the same cycle as a loss of lock gives `w_err` = 1 and `w_err_cnt` = 1.
- **Reset and saturation:**
  - Stimulus: assert `reset` mid-lock. Separately, force 260 lock/unlock cycles.
  - Required: on reset, all outputs are 0 immediately and relock follows the normal sequence. Under the 260 cycles, `w_err_cnt` saturates at 255.
